// File: rtl/rr4_mux_arbiter_pkg.sv
// Shared constants and types for the four-channel round-robin mux arbiter.
// Channel indices double as the {s1,s0} mux select encoding.
package rr4_mux_arbiter_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/m41.sv
// Single-bit 4:1 multiplexer; {s1,s0} selects a, b, c, d in that order.
module m41 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  input  logic s1_i,
  input  logic s0_i,
  output logic y_o
);

  assign y_o = s1_i ? (s0_i ? d_i : c_i) : (s0_i ? b_i : a_i);

endmodule

// File: rtl/rr4_mux_arbiter_pick.sv
// Rotating priority picker: first set bit of req scanning ptr, ptr+1, ... mod 4.
module rr4_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the closest candidate to ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr4_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux datapath, with a burst-hold
// limit that forces a handover once the owner has held MAX_HOLD cycles.
module rr4_mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  import rr4_mux_arbiter_pkg::*;

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         hold_q, hold_d;
  logic [WIDTH-1:0]   out_q;
  logic               valid_q;
  logic [WIDTH-1:0]   muxY;

  logic [3:0]         pickReq;
  logic [1:0]         pickPtr;
  logic               pickFound;
  logic [1:0]         pickIdx;
  logic [1:0]         nextPtr;
  logic               holdFull;

  // While busy the owner is masked out and scanning starts just after it,
  // so one picker serves fresh grants, releases and forced handovers.
  assign nextPtr  = sel_q + 2'd1;
  assign pickReq  = (state_q == ST_BUSY) ? (req & ~gnt_q) : req;
  assign pickPtr  = (state_q == ST_BUSY) ? nextPtr : ptr_q;
  assign holdFull = (hold_q == 4'(MAX_HOLD));

  rr4_pick u_pick (
    .req   (pickReq),
    .ptr   (pickPtr),
    .found (pickFound),
    .idx   (pickIdx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pickFound) begin
          sel_d   = pickIdx;
          gnt_d   = onehot4(pickIdx);
          hold_d  = 4'd1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req[sel_q]) begin
          ptr_d = nextPtr;
          if (pickFound) begin
            sel_d  = pickIdx;
            gnt_d  = onehot4(pickIdx);
            hold_d = 4'd1;
          end else begin
            gnt_d   = '0;
            hold_d  = 4'd0;
            state_d = ST_IDLE;
          end
        end else if (holdFull && pickFound) begin
          ptr_d  = nextPtr;
          sel_d  = pickIdx;
          gnt_d  = onehot4(pickIdx);
          hold_d = 4'd1;
        end else if (holdFull) begin
          hold_d = 4'd1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= CH_A;
      ptr_q   <= CH_A;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    m41 u_mux (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .c_i  (c[i]),
      .d_i  (d[i]),
      .s1_i (sel_q[1]),
      .s0_i (sel_q[0]),
      .y_o  (muxY[i])
    );
  end

  // out only captures while a grant is live, so it keeps the last owner's data after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= |gnt_q;
      if (|gnt_q) out_q <= muxY;
    end
  end

  assign gnt       = gnt_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr4_mux_arbiter.sv
// Directed bench for rr4_mux_arbiter (WIDTH=1, MAX_HOLD=4) with hand-computed expectations.
module tb_rr4_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [0:0] a, b, c, d;
  logic [3:0] gnt;
  logic       s1, s0;
  logic [0:0] out;
  logic       out_valid;

  int passCount;
  int checkCount;

  rr4_mux_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .gnt       (gnt),
    .s1        (s1),
    .s0        (s0),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'($urandom_range(0, 15));
    {a, b, c, d} = 4'($urandom_range(0, 15));
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if (gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt);
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
    else passCount++;
    checkCount++;
    if ({s1, s0} !== 2'b00) $display("[TB] FAIL reset_sel: got %b expected 00", {s1, s0});
    else passCount++;
    checkCount++;
    if (out !== 1'b0) $display("[TB] FAIL reset_out: got %b expected 0", out);
    else passCount++;
    for (int i = 0; i < 2; i++) begin
      req = 4'($urandom_range(1, 15));
      tick();
      checkCount++;
      if (gnt !== 4'b0000) $display("[TB] FAIL reset_hold_gnt: got %b expected 0000", gnt);
      else passCount++;
    end
    rst = 1'b0;
    req = 4'b0100;
    a = 1'b0; b = 1'b0; c = 1'b1; d = 1'b0;
    tick();
    checkCount++;
    if (gnt !== 4'b0100) $display("[TB] FAIL first_gnt: got %b expected 0100", gnt);
    else passCount++;
    checkCount++;
    if ({s1, s0} !== 2'b10) $display("[TB] FAIL first_sel: got %b expected 10", {s1, s0});
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL first_valid_early: got %b expected 0", out_valid);
    else passCount++;
    tick();
    checkCount++;
    if (out !== 1'b1 || out_valid !== 1'b1)
      $display("[TB] FAIL first_data: got out=%b valid=%b expected out=1 valid=1", out, out_valid);
    else passCount++;
  endtask

  task automatic test_single_requester();
    doReset();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkCount++;
      if (gnt !== 4'b0001) $display("[TB] FAIL single_gnt[%0d]: got %b expected 0001", i, gnt);
      else passCount++;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] expG;
    logic [1:0] expS;
    doReset();
    req = 4'b1111;
    for (int i = 0; i < 18; i++) begin
      tick();
      expS = 2'((i / 4) % 4);
      expG = 4'b0001 << expS;
      checkCount++;
      if (gnt !== expG || {s1, s0} !== expS)
        $display("[TB] FAIL rotate[%0d]: got gnt=%b sel=%b expected gnt=%b sel=%b",
                 i, gnt, {s1, s0}, expG, expS);
      else passCount++;
    end
  endtask

  task automatic test_handover();
    doReset();
    a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b1;
    req = 4'b0001;
    tick();
    checkCount++;
    if (gnt !== 4'b0001) $display("[TB] FAIL ho_start: got %b expected 0001", gnt);
    else passCount++;
    req = 4'b1010;
    tick();
    checkCount++;
    if (gnt !== 4'b0010) $display("[TB] FAIL ho_release: got %b expected 0010", gnt);
    else passCount++;
    req = 4'b1000;
    tick();
    checkCount++;
    if (gnt !== 4'b1000 || {s1, s0} !== 2'b11)
      $display("[TB] FAIL ho_to_d: got gnt=%b sel=%b expected gnt=1000 sel=11", gnt, {s1, s0});
    else passCount++;
    req = 4'b0000;
    tick();
    checkCount++;
    if (gnt !== 4'b0000 || out_valid !== 1'b1)
      $display("[TB] FAIL ho_drop: got gnt=%b valid=%b expected gnt=0000 valid=1", gnt, out_valid);
    else passCount++;
    d = 1'b0;
    tick();
    checkCount++;
    if (out_valid !== 1'b0 || out !== 1'b1)
      $display("[TB] FAIL ho_idle: got valid=%b out=%b expected valid=0 out=1", out_valid, out);
    else passCount++;
  endtask

  task automatic test_wrap_data();
    req = 4'b1001;
    tick();
    checkCount++;
    if (gnt !== 4'b0001) $display("[TB] FAIL wrap_gnt: got %b expected 0001", gnt);
    else passCount++;
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b0;
    tick();
    checkCount++;
    if (out !== 1'b1 || out_valid !== 1'b1)
      $display("[TB] FAIL data_a1: got out=%b valid=%b expected out=1 valid=1", out, out_valid);
    else passCount++;
    a = 1'b0;
    tick();
    checkCount++;
    if (out !== 1'b0) $display("[TB] FAIL data_a0: got %b expected 0", out);
    else passCount++;
    a = 1'b1;
    req = 4'b0010;
    tick();
    checkCount++;
    if (gnt !== 4'b0010 || out !== 1'b1)
      $display("[TB] FAIL data_switch: got gnt=%b out=%b expected gnt=0010 out=1", gnt, out);
    else passCount++;
    tick();
    checkCount++;
    if (out !== 1'b0) $display("[TB] FAIL data_b: got %b expected 0", out);
    else passCount++;
  endtask

  task automatic test_reset_mid_busy();
    doReset();
    a = 1'b0; b = 1'b0; c = 1'b1; d = 1'b0;
    req = 4'b0100;
    tick();
    tick();
    tick();
    checkCount++;
    if (gnt !== 4'b0100 || out_valid !== 1'b1 || out !== 1'b1)
      $display("[TB] FAIL mid_busy: got gnt=%b valid=%b out=%b expected 0100/1/1", gnt, out_valid, out);
    else passCount++;
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if (gnt !== 4'b0000 || {s1, s0} !== 2'b00 || out !== 1'b0 || out_valid !== 1'b0)
      $display("[TB] FAIL mid_reset: got gnt=%b sel=%b out=%b valid=%b expected all zero",
               gnt, {s1, s0}, out, out_valid);
    else passCount++;
    req = 4'b0101;
    #1 rst = 1'b0;
    tick();
    checkCount++;
    if (gnt !== 4'b0001) $display("[TB] FAIL mid_regrant: got %b expected 0001", gnt);
    else passCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst = 1'b0;
    req = 4'b0000;
    a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;
    test_reset();
    test_single_requester();
    test_fairness();
    test_handover();
    test_wrap_data();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
